// File: rtl/i1_pkg.sv
// Shared types for the i1 request encoder.
// State encoding, request bundle and one-hot line helper.
package i1_pkg;

   localparam int LINE_W = 7;
   localparam int CODE_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      WAIT,
      REPORT
   } state_t;

   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic              dir;
      logic              pri;
   } req_t;

   // Code 0 is a null request and selects no line.
   function automatic logic [LINE_W-1:0] onehot_line(
      input logic [CODE_W-1:0] code
   );
      logic [LINE_W-1:0] v;
      v = '0;
      if (code != '0) v[code - 1'b1] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/i1_req_encoder_if.sv
// Request, decoder and completion signals of the i1 encoder.
// slave is the encoder view; master is the source/decoder view.
interface i1_req_encoder_if;
   import i1_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [CODE_W-1:0] req_code;
   logic              req_dir;
   logic              req_pri;
   logic [LINE_W-1:0] dec_lines;
   logic              dec_dir;
   logic              dec_pri;
   logic              dec_en;
   logic              dec_phase;
   logic              st_a;
   logic              st_b;
   logic              done_valid;
   logic [1:0]        done_status;
   logic              done_err;

   modport slave (
      input  req_valid, req_code, req_dir, req_pri,
      input  st_a, st_b,
      output req_ready,
      output dec_lines, dec_dir, dec_pri, dec_en, dec_phase,
      output done_valid, done_status, done_err
   );

   modport master (
      output req_valid, req_code, req_dir, req_pri,
      output st_a, st_b,
      input  req_ready,
      input  dec_lines, dec_dir, dec_pri, dec_en, dec_phase,
      input  done_valid, done_status, done_err
   );

endinterface

// File: rtl/i1_req_fifo.sv
// Synchronous request queue, no bypass path.
// Pointers carry one wrap bit to separate full from empty.
module i1_req_fifo
   import i1_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  req_t wdata,
   input  logic pop,
   output req_t rdata,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   req_t        mem [DEPTH];

   logic do_push;
   logic do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/i1_req_encoder.sv
// Encodes queued line requests for the i1 decoder and waits
// for its state response, tracking the phase bit across requests.
module i1_req_encoder
   import i1_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   i1_req_encoder_if.slave  bus
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t           state_q;
   state_t           state_d;
   req_t             cur_q;
   req_t             head;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [1:0]       status_q;
   logic             err_q;
   logic             phase_q;

   logic       full;
   logic       empty;
   logic       pop;
   logic       cap;
   logic [1:0] cap_status;
   logic       cap_err;
   logic       active;
   req_t       wdata;

   assign wdata = '{code: bus.req_code, dir: bus.req_dir, pri: bus.req_pri};
   assign bus.req_ready = !full;

   i1_req_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (bus.req_valid),
      .wdata (wdata),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pop        = 1'b0;
      cap        = 1'b0;
      cap_status = 2'b00;
      cap_err    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A response on the last allowed cycle still wins.
            if (bus.st_a || bus.st_b) begin
               cap        = 1'b1;
               cap_status = {bus.st_a, bus.st_b};
               state_d    = REPORT;
            end else if (cnt_q == CNT_LAST) begin
               cap     = 1'b1;
               cap_err = 1'b1;
               state_d = REPORT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         REPORT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cur_q    <= '0;
         cnt_q    <= '0;
         status_q <= 2'b00;
         err_q    <= 1'b0;
         phase_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (pop) cur_q <= head;
         if (cap) begin
            status_q <= cap_status;
            err_q    <= cap_err;
         end
         if (state_q == REPORT && !err_q) phase_q <= status_q[1];
      end
   end

   assign active = (state_q == DRIVE) || (state_q == WAIT);

   assign bus.dec_en      = active;
   assign bus.dec_lines   = active ? onehot_line(cur_q.code) : '0;
   assign bus.dec_dir     = active & cur_q.dir;
   assign bus.dec_pri     = active & cur_q.pri;
   assign bus.dec_phase   = phase_q;
   assign bus.done_valid  = (state_q == REPORT);
   assign bus.done_status = bus.done_valid ? status_q : 2'b00;
   assign bus.done_err    = bus.done_valid & err_q;

endmodule

// File: tb/tb_i1_req_encoder.sv
// Bench for i1_req_encoder: directed table, backpressure,
// randomized traffic and mid-transaction reset.
module tb_i1_req_encoder;
   import i1_pkg::*;

   localparam int T = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   i1_req_encoder_if bus ();

   i1_req_encoder #(
      .FIFO_DEPTH  (4),
      .TIMEOUT_CYC (T)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [2:0] code;
      logic       dir;
      logic       pri;
      logic       a;
      logic       b;
      int         delay;
   } plan_t;

   typedef struct {
      logic [2:0] code;
      logic       dir;
      logic       pri;
      logic       a;
      logic       b;
      int         delay;
      logic [6:0] lines;
      logic [1:0] status;
      logic       err;
      logic       phase;
   } vec_t;

   int errors = 0;
   int checks = 0;

   plan_t plan_q[$];
   plan_t cur;
   bit    mon_en = 1'b0;
   int    en_len = 0;
   int    last_len = 0;
   int    done_cnt = 0;
   logic  exp_phase = 1'b0;
   logic  respond;
   logic [1:0] exp_st;
   logic [6:0] seen_lines;
   logic  seen_dir;
   logic  seen_pri;
   logic [1:0] seen_status;
   logic  seen_err;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] line_of(logic [2:0] c);
      int n;
      n = (c == 0) ? 0 : (1 << (int'(c) - 1));
      return 7'(n);
   endfunction

   function automatic bit timed_out(plan_t p);
      return !(p.a || p.b) || (p.delay >= T);
   endfunction

   // Decoder model and scoreboard, sampled away from the active edge.
   always @(negedge clk) begin
      if (!mon_en) begin
         bus.st_a = 1'b0;
         bus.st_b = 1'b0;
         en_len = 0;
      end else begin
         if (bus.dec_en) begin
            en_len++;
            if (en_len == 1) begin
               if (plan_q.size() == 0) begin
                  chk("unexpected_drive", 1, 0);
               end else begin
                  cur = plan_q.pop_front();
                  seen_lines = bus.dec_lines;
                  seen_dir = bus.dec_dir;
                  seen_pri = bus.dec_pri;
               end
            end
            chk("lines_held", bus.dec_lines, line_of(cur.code));
            chk("dir_held", bus.dec_dir, cur.dir);
            chk("pri_held", bus.dec_pri, cur.pri);
            respond = (en_len >= 2 + cur.delay);
            bus.st_a = respond & cur.a;
            bus.st_b = respond & cur.b;
         end else begin
            if (en_len != 0) last_len = en_len;
            en_len = 0;
            bus.st_a = 1'b0;
            bus.st_b = 1'b0;
         end
         if (bus.done_valid) begin
            seen_status = bus.done_status;
            seen_err = bus.done_err;
            exp_st = timed_out(cur) ? 2'b00 : {cur.a, cur.b};
            chk("spurious_done", (last_len != 0), 1);
            chk("done_status", bus.done_status, exp_st);
            chk("done_err", bus.done_err, timed_out(cur));
            chk("en_cycles", last_len,
                timed_out(cur) ? T + 1 : cur.delay + 2);
            chk("phase_at_done", bus.dec_phase, exp_phase);
            if (!timed_out(cur)) exp_phase = cur.a;
            last_len = 0;
            done_cnt++;
         end
      end
   end

   task automatic push(input plan_t p, output int waited);
      bus.req_code = p.code;
      bus.req_dir = p.dir;
      bus.req_pri = p.pri;
      bus.req_valid = 1'b1;
      waited = 0;
      while (!bus.req_ready && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.req_ready) chk("push_timeout", 0, 1);
      else plan_q.push_back(p);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_done(input int n);
      int t;
      t = 0;
      while (done_cnt < n && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (done_cnt < n) chk("done_timeout", done_cnt, n);
   endtask

   vec_t  vec[8];
   plan_t p;
   int    w;
   int    base;

   initial begin
      bus.req_valid = 1'b0;
      bus.req_code = '0;
      bus.req_dir = 1'b0;
      bus.req_pri = 1'b0;

      vec[0] = '{3'd3, 0, 0, 1, 0, 0,  7'b0000100, 2'b10, 0, 1};
      vec[1] = '{3'd5, 0, 0, 0, 1, 0,  7'b0010000, 2'b01, 0, 0};
      vec[2] = '{3'd7, 1, 1, 1, 1, 3,  7'b1000000, 2'b11, 0, 1};
      vec[3] = '{3'd0, 0, 1, 0, 0, 0,  7'b0000000, 2'b00, 1, 1};
      vec[4] = '{3'd0, 1, 0, 0, 1, 0,  7'b0000000, 2'b01, 0, 0};
      vec[5] = '{3'd1, 1, 0, 1, 0, 14, 7'b0000001, 2'b10, 0, 1};
      vec[6] = '{3'd2, 0, 0, 1, 0, 15, 7'b0000010, 2'b00, 1, 1};
      vec[7] = '{3'd6, 0, 1, 0, 1, 0,  7'b0100000, 2'b01, 0, 0};

      repeat (2) @(negedge clk);
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_en", bus.dec_en, 0);
      chk("rst_lines", bus.dec_lines, 0);
      chk("rst_done", bus.done_valid, 0);
      chk("rst_status", bus.done_status, 0);
      chk("rst_err", bus.done_err, 0);
      chk("rst_phase", bus.dec_phase, 0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         p = '{vec[i].code, vec[i].dir, vec[i].pri,
               vec[i].a, vec[i].b, vec[i].delay};
         base = done_cnt;
         push(p, w);
         wait_done(base + 1);
         chk($sformatf("v%0d_lines", i), seen_lines, vec[i].lines);
         chk($sformatf("v%0d_dir", i), seen_dir, vec[i].dir);
         chk($sformatf("v%0d_pri", i), seen_pri, vec[i].pri);
         chk($sformatf("v%0d_status", i), seen_status, vec[i].status);
         chk($sformatf("v%0d_err", i), seen_err, vec[i].err);
         @(negedge clk);
         chk($sformatf("v%0d_phase", i), bus.dec_phase, vec[i].phase);
      end

      // Backpressure with a silent decoder.
      base = done_cnt;
      for (int i = 0; i < 5; i++) begin
         p = '{3'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0, 0};
         push(p, w);
         chk($sformatf("bp_push%0d_wait", i), w, 0);
      end
      chk("bp_ready_low", bus.req_ready, 0);
      p = '{3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 0};
      push(p, w);
      chk("bp_sixth_held", (w >= 10), 1);
      wait_done(base + 6);

      // Randomized traffic.
      base = done_cnt;
      for (int i = 0; i < 40; i++) begin
         p.code = 3'($urandom_range(0, 7));
         p.dir = 1'($urandom_range(0, 1));
         p.pri = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0: begin p.a = 1'b0; p.b = 1'b0; end
            1: begin p.a = 1'b1; p.b = 1'b1; end
            2: begin p.a = 1'b1; p.b = 1'b0; end
            default: begin p.a = 1'b0; p.b = 1'b1; end
         endcase
         p.delay = ($urandom_range(0, 7) == 0) ?
                   int'($urandom_range(10, 17)) : int'($urandom_range(0, 3));
         push(p, w);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_done(base + 40);

      // Reset in the middle of a transaction with one more queued.
      p = '{3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 0};
      push(p, w);
      push(p, w);
      w = 0;
      while (!bus.dec_en && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("mid_rst_started", bus.dec_en, 1);
      repeat (3) @(negedge clk);
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_en", bus.dec_en, 0);
      chk("mid_rst_lines", bus.dec_lines, 0);
      chk("mid_rst_done", bus.done_valid, 0);
      chk("mid_rst_ready", bus.req_ready, 1);
      @(negedge clk);
      plan_q.delete();
      exp_phase = 1'b0;
      last_len = 0;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_idle", {bus.dec_en, bus.done_valid}, 0);
      end
      chk("post_rst_ready", bus.req_ready, 1);
      mon_en = 1'b1;
      @(negedge clk);

      base = done_cnt;
      p = '{3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1};
      push(p, w);
      wait_done(base + 1);
      chk("post_rst_lines", seen_lines, 7'b0001000);
      chk("post_rst_status", seen_status, 2'b10);
      @(negedge clk);
      chk("post_rst_phase", bus.dec_phase, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
